data_bus_arbiter: RTL
=====================

Name: data_bus_arbiter

Overview:
- Two-requester arbiter/sequencer sharing the single data memory port (synchronous-read RAM behind the memory map decoder).
- Requester 0 is the core data path (load/store); requester 1 is a DMA/debug master (UART loader, test access).
- Serializes accesses with a 3-state FSM, applies round-robin arbitration, and returns a registered ack, read data and a stall flag so the core can hold its PC.

Parameters:
- ADDR_LENGTH, 32, address width of both requesters and the memory port.
- DATA_LENGTH, 32, data width of both requesters and the memory port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0 write (1) / read (0); stable while req0 high.
- addr0  input  ADDR_LENGTH  requester 0 address; stable while req0 high.
- wdata0  input  DATA_LENGTH  requester 0 write data; stable while req0 high.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DATA_LENGTH  requester 0 read data; valid while ack0=1.
- stall0  output  1  req0 & ~ack0; drives the core PC hold.
- req1, we1, addr1, wdata1, ack1, rdata1  same as requester 0, for requester 1.
- mem_addr  output  ADDR_LENGTH  memory address.
- mem_wdata  output  DATA_LENGTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_rdata  input  DATA_LENGTH  memory read data; valid the cycle after mem_re.
- busy  output  1  1 whenever the FSM is not in IDLE.
- gnt_id  output  1  index of the current or last granted requester.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - ack0 = ack1 = 0, mem_we = mem_re = 0, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - gnt_id = 1, so requester 0 wins the first tie.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to gnt_id.
  - On a grant, register gnt_id, mem_addr, mem_wdata, mem_we = we_x and mem_re = ~we_x, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Memory strobes are high for this cycle only.
  - Next state is RESP; mem_we and mem_re are cleared at the exit edge.
- RESP (exactly 1 cycle):
  - ack_gnt = 1.
  - rdata_gnt = mem_rdata for reads; unchanged for writes.
  - The other ack stays 0. Next state is IDLE.
- Latency and throughput:
  - A req first sampled high at edge N gives mem strobe in cycle N+1 and ack in cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
  - With continuous contention, grants strictly alternate 0,1,0,1.
- Handshake rules:
  - The requester deasserts req, or presents a new request, on the cycle after ack.
  - req is sampled only in IDLE, so a req still high in the ack cycle is not double-served. The FSM is back in IDLE by then and the requester has had the cycle to drop it.
  - req dropped before ack (protocol violation): the transaction still completes and ack still pulses.
  - Address and data are captured at grant; later changes are ignored.
- stall0 is combinational: high from req0 assertion until the ack0 cycle inclusive-exclusive, i.e. low in the ack0 cycle.
- Reset mid-operation: rst high at any edge forces IDLE and clears mem_we/mem_re at that edge. A pending write in ISSUE is aborted, and no ack is issued for the aborted transaction.
- No arithmetic: addresses pass through unmodified; the decoder above does region select.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both req are high. Requester 1 may starve while the core streams accesses; gnt_id is still updated.
- Undefined (default): round-robin as specified above.

Test Plan:
- Read path: after reset, req0=1, we0=0, addr0=0x1001_0004, RAM[that]=0xDEAD_BEEF.
  - mem_re=1 with mem_addr=0x1001_0004 in cycle 1.
  - ack0=1 with rdata0=0xDEAD_BEEF in cycle 2; stall0 high in cycles 0–1.
- Write path: req1=1, we1=1, addr1=0x1001_0008, wdata1=0x0000_00A5.
  - mem_we=1 for exactly 1 cycle with those values; ack1 one cycle later.
  - A subsequent req0 read of 0x1001_0008 returns 0x0000_00A5.
- Contention: req0 and req1 held high continuously for 4 transactions.
  - Ack order is 0,1,0,1; acks land at cycles 2,5,8,11; ack0 and ack1 are never high together.
- Reset abort: assert rst during ISSUE of a requester-0 write to 0x1001_000C.
  - mem_we=0 the next cycle, ack0 is never pulsed, busy=0.
  - RAM[0x1001_000C] is unchanged, provided the write had not yet been clocked into the RAM; mem_we was high only in that ISSUE cycle.
- Late request: req1 raised while requester 0 is in ISSUE.
  - Requester 1 is not granted until after ack0; it is granted at the next IDLE, and gnt_id = 1 during its transaction.
- Fixed priority (ARB_FIXED_PRIO_EN defined): both req held high for 3 transactions.
  - All 3 acks go to requester 0; ack1 stays 0 until req0 drops.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory port.
// slave is the arbiter's view; master is the view of the surrounding requesters and memory.
interface data_bus_arbiter_if #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DATA_LENGTH = 32
);
    logic                   req0;
    logic                   we0;
    logic [ADDR_LENGTH-1:0] addr0;
    logic [DATA_LENGTH-1:0] wdata0;
    logic                   ack0;
    logic [DATA_LENGTH-1:0] rdata0;
    logic                   stall0;

    logic                   req1;
    logic                   we1;
    logic [ADDR_LENGTH-1:0] addr1;
    logic [DATA_LENGTH-1:0] wdata1;
    logic                   ack1;
    logic [DATA_LENGTH-1:0] rdata1;

    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [DATA_LENGTH-1:0] mem_rdata;

    logic                   busy;
    logic                   gnt_id;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, stall0,
        output ack1, rdata1,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy, gnt_id
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, stall0,
        input  ack1, rdata1,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, gnt_id
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter/sequencer for the single synchronous-read data memory port.
// Round-robin by default; define ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module data_bus_arbiter #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DATA_LENGTH = 32
) (
    input logic         clk,
    input logic         rst,
    data_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic                   op_we_q, op_we_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic [ADDR_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_LENGTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_LENGTH-1:0] rdata1_q, rdata1_d;
    logic                   pick;
    logic                   resp_rd;

    // pick is only consulted when at least one request is present.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        pick = ~bus.req0;
`else
        if (bus.req0 && bus.req1) begin
            pick = ~gnt_q;
        end else begin
            pick = bus.req1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        op_we_d     = op_we_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d       = pick;
                    op_we_d     = pick ? bus.we1 : bus.we0;
                    mem_addr_d  = pick ? bus.addr1 : bus.addr0;
                    mem_wdata_d = pick ? bus.wdata1 : bus.wdata0;
                    mem_we_d    = op_we_d;
                    mem_re_d    = ~op_we_d;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                mem_we_d = 1'b0;
                mem_re_d = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                if (!op_we_q) begin
                    if (gnt_q) begin
                        rdata1_d = bus.mem_rdata;
                    end else begin
                        rdata0_d = bus.mem_rdata;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b1;
            op_we_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            op_we_q     <= op_we_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Read data arrives from the RAM during RESP, so it is forwarded in the ack cycle
    // and held in the rdata registers afterwards.
    assign resp_rd = (state_q == StResp) && !op_we_q;

    assign bus.ack0      = (state_q == StResp) && !gnt_q;
    assign bus.ack1      = (state_q == StResp) && gnt_q;
    assign bus.rdata0    = (resp_rd && !gnt_q) ? bus.mem_rdata : rdata0_q;
    assign bus.rdata1    = (resp_rd && gnt_q) ? bus.mem_rdata : rdata1_q;
    assign bus.stall0    = bus.req0 && !bus.ack0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.gnt_id    = gnt_q;

endmodule
